// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg -- shared definitions for the multicycle RISC-V controller.
// Holds the FSM state encoding, the major-opcode constants, the ALUControl
// codes, the srcA/srcB/writeback select encodings, and small decode helpers
// used by the controller and the ALU decoder.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRTGT  = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] SRCA_RD1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;
    localparam logic       SRCB_RD2  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef struct packed {
        logic [1:0] src_a;
        logic       src_b;
    } operand_sel_t;

    // True for every major opcode the controller knows how to sequence.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32,
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
        return legal;
    endfunction

    // ALU operand sources held from EXEC to the last cycle of the instruction.
    function automatic operand_sel_t operand_sel(input logic [6:0] opc);
        operand_sel_t sel;
        case (opc)
            OPC_OP, OPC_OP_32, OPC_BRANCH: sel = '{src_a: SRCA_RD1,  src_b: SRCB_RD2};
            OPC_LUI:                       sel = '{src_a: SRCA_ZERO, src_b: SRCB_IMM};
            OPC_AUIPC, OPC_JAL:            sel = '{src_a: SRCA_PC,   src_b: SRCB_IMM};
            default:                       sel = '{src_a: SRCA_RD1,  src_b: SRCB_IMM};
        endcase
        return sel;
    endfunction

    // Branch condition from the flags of rs1 - rs2 (carry set means no borrow).
    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic n, input logic c, input logic v);
        logic tk;
        case (f3)
            3'b000:  tk = z;
            3'b001:  tk = ~z;
            3'b100:  tk = n ^ v;
            3'b101:  tk = ~(n ^ v);
            3'b110:  tk = ~c;
            3'b111:  tk = c;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder -- combinational map from instruction fields to ALU function.
// Ports:
//   opcode  [6:0] in   major opcode
//   funct3  [2:0] in   instr[14:12]
//   funct7        in   instr[30]
//   alu_control [3:0] out  ALUControl code
//   word          out  32-bit (W-form) operation
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output logic [3:0] alu_control,
    output logic       word
);

    logic is_reg_form_s;

    // Decode the ALU function; funct7 only separates SUB from ADD on
    // register-register forms, but always separates SRA from SRL.
    always_comb begin
        alu_control   = ALU_ADD;
        is_reg_form_s = (opcode == OPC_OP) || (opcode == OPC_OP_32);
        word          = ((opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32)) ? 1'b1 : 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_32, OPC_OP_IMM, OPC_OP_IMM_32: begin
                case (funct3)
                    3'b000:  alu_control = (funct7 && is_reg_form_s) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            OPC_BRANCH: alu_control = ALU_SUB;
            default:    alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller -- FSM sequencing a multicycle RV64 datapath.
// Ports:
//   clk, rst (async, active-low)
//   opcode/funct3/funct7       instruction fields from the IR
//   Zero/Negative/Carry/Overflow  ALU flags (Carry=1: no borrow)
//   imem_ready, dmem_ready     memory handshakes
//   pc_write, ir_write, regWriteEnable, load, store, word, ALUControl,
//   JALR, sel_mux_pcnext, sel_mux_srcB, sel_mux_srcA, sel_mux_writeback
//                              datapath controls
//   illegal                    sticky trap flag
//   instret [N-1:0]            count of cycles with pc_write=1
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int N = 64
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7,
    input  logic         Zero,
    input  logic         Negative,
    input  logic         Carry,
    input  logic         Overflow,
    input  logic         imem_ready,
    input  logic         dmem_ready,
    output logic         pc_write,
    output logic         ir_write,
    output logic         regWriteEnable,
    output logic         load,
    output logic         store,
    output logic         word,
    output logic [3:0]   ALUControl,
    output logic         JALR,
    output logic         sel_mux_pcnext,
    output logic         sel_mux_srcB,
    output logic [1:0]   sel_mux_srcA,
    output logic [1:0]   sel_mux_writeback,
    output logic         illegal,
    output logic [N-1:0] instret
);

    state_t         state_q, state_d;
    logic           taken_q, taken_d;
    logic           illegal_q, illegal_d;
    logic [N-1:0]   instret_q, instret_d;

    logic [3:0]     dec_alu_s;
    logic           dec_word_s;
    operand_sel_t   opsel_s;

    logic           pc_write_s, ir_write_s, reg_write_s, load_s, store_s, word_s;
    logic [3:0]     alu_ctl_s;
    logic           jalr_s, pcnext_s, src_b_s;
    logic [1:0]     src_a_s, wb_sel_s;

    alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu_s),
        .word        (dec_word_s)
    );

    assign opsel_s = operand_sel(opcode);

    // Next-state and control decode; every output is forced low while reset
    // is held so no enable can leak out of an abandoned instruction.
    always_comb begin
        state_d     = state_q;
        taken_d     = taken_q;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        load_s      = 1'b0;
        store_s     = 1'b0;
        word_s      = 1'b0;
        alu_ctl_s   = ALU_ADD;
        jalr_s      = 1'b0;
        pcnext_s    = 1'b0;
        src_b_s     = SRCB_RD2;
        src_a_s     = SRCA_RD1;
        wb_sel_s    = WB_ALU;

        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    ir_write_s = 1'b1;
                    state_d    = DECODE;
                end else begin
                    state_d    = FETCH;
                end
            end
            DECODE: begin
                state_d = is_legal_opcode(opcode) ? EXEC : TRAP;
            end
            EXEC: begin
                src_a_s   = opsel_s.src_a;
                src_b_s   = opsel_s.src_b;
                alu_ctl_s = dec_alu_s;
                word_s    = dec_word_s;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = MEM;
                    OPC_BRANCH: begin
                        if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
                            state_d = TRAP;
                        end else begin
                            taken_d = branch_taken(funct3, Zero, Negative, Carry, Overflow);
                            state_d = BRTGT;
                        end
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                // Address stays rs1 + imm for the whole access.
                src_a_s   = SRCA_RD1;
                src_b_s   = SRCB_IMM;
                alu_ctl_s = ALU_ADD;
                load_s    = (opcode == OPC_LOAD);
                store_s   = (opcode == OPC_STORE);
                if (dmem_ready) begin
                    if (opcode == OPC_LOAD) begin
                        state_d = WB;
                    end else begin
                        // Stores retire here: advance to pc+4.
                        pc_write_s = 1'b1;
                        pcnext_s   = 1'b0;
                        state_d    = FETCH;
                    end
                end else begin
                    state_d = MEM;
                end
            end
            WB: begin
                src_a_s     = opsel_s.src_a;
                src_b_s     = opsel_s.src_b;
                alu_ctl_s   = dec_alu_s;
                word_s      = dec_word_s;
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                jalr_s      = (opcode == OPC_JALR);
                case (opcode)
                    OPC_LOAD: wb_sel_s = WB_LOAD;
                    OPC_JAL, OPC_JALR: begin
                        wb_sel_s = WB_PC4;
                        pcnext_s = 1'b1;
                    end
                    default:  wb_sel_s = WB_ALU;
                endcase
                state_d = FETCH;
            end
            BRTGT: begin
                // ALU now forms pc + imm; PC only loads if the branch was taken.
                src_a_s    = SRCA_PC;
                src_b_s    = SRCB_IMM;
                alu_ctl_s  = ALU_ADD;
                pcnext_s   = 1'b1;
                pc_write_s = taken_q;
                state_d    = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase

        if (!rst) begin
            pc_write_s  = 1'b0;
            ir_write_s  = 1'b0;
            reg_write_s = 1'b0;
            load_s      = 1'b0;
            store_s     = 1'b0;
            word_s      = 1'b0;
            alu_ctl_s   = ALU_ADD;
            jalr_s      = 1'b0;
            pcnext_s    = 1'b0;
            src_b_s     = SRCB_RD2;
            src_a_s     = SRCA_RD1;
            wb_sel_s    = WB_ALU;
        end else begin
            // Out of reset the decoded controls pass through unchanged.
            state_d = state_d;
        end

        illegal_d = illegal_q | (state_d == TRAP);
        instret_d = instret_q + {{(N-1){1'b0}}, pc_write_s};
    end

    // State, branch decision, trap flag and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= {N{1'b0}};
        end else begin
            state_q   <= state_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign pc_write          = pc_write_s;
    assign ir_write          = ir_write_s;
    assign regWriteEnable    = reg_write_s;
    assign load              = load_s;
    assign store             = store_s;
    assign word              = word_s;
    assign ALUControl        = alu_ctl_s;
    assign JALR              = jalr_s;
    assign sel_mux_pcnext    = pcnext_s;
    assign sel_mux_srcB      = src_b_s;
    assign sel_mux_srcA      = src_a_s;
    assign sel_mux_writeback = wb_sel_s;
    assign illegal           = illegal_q;
    assign instret           = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller -- scoreboard bench for multicycle_controller.
// Each stimulus cycle pushes the expected control vector and instret; a
// negedge monitor pops and compares against the DUT.
module tb_multicycle_controller;

    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic        Zero, Negative, Carry, Overflow;
    logic        imem_ready, dmem_ready;
    logic        pc_write, ir_write, regWriteEnable, load, store, word;
    logic [3:0]  ALUControl;
    logic        JALR, sel_mux_pcnext, sel_mux_srcB;
    logic [1:0]  sel_mux_srcA, sel_mux_writeback;
    logic        illegal;
    logic [63:0] instret;

    typedef struct {
        logic [17:0] ctrl;
        logic [63:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_ret;
    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_tag  = "reset";
    logic [17:0] obs;

    assign obs = {pc_write, ir_write, regWriteEnable, load, store, word, ALUControl,
                  JALR, sel_mux_pcnext, sel_mux_srcB, sel_mux_srcA, sel_mux_writeback, illegal};

    multicycle_controller #(.N(64)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .regWriteEnable(regWriteEnable),
        .load(load), .store(store), .word(word), .ALUControl(ALUControl), .JALR(JALR),
        .sel_mux_pcnext(sel_mux_pcnext), .sel_mux_srcB(sel_mux_srcB),
        .sel_mux_srcA(sel_mux_srcA), .sel_mux_writeback(sel_mux_writeback),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control vector, same bit order as obs.
    function automatic logic [17:0] ev(input logic pcw, input logic irw, input logic rwe,
                                       input logic ld, input logic st, input logic wd,
                                       input logic [3:0] alu, input logic jl, input logic pcn,
                                       input logic sb, input logic [1:0] sa, input logic [1:0] wb,
                                       input logic ill);
        return {pcw, irw, rwe, ld, st, wd, alu, jl, pcn, sb, sa, wb, ill};
    endfunction

    // Scoreboard monitor: compare one expected entry per cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq({cur_tag, ":ctrl"}, 64'(obs), 64'(e.ctrl));
            check_eq({cur_tag, ":instret"}, instret, e.ret);
        end
    end

    task automatic step(input logic [17:0] v);
        exp_t e;
        e.ctrl = v;
        e.ret  = model_ret;
        exp_q.push_back(e);
        if (v[17]) model_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int waits);
        imem_ready = L0;
        for (int i = 0; i < waits; i++) step(18'd0);
        imem_ready = L1;
        step(ev(L0, L1, L0, L0, L0, L0, 4'd0, L0, L0, L0, 2'd0, 2'd0, L0));
    endtask

    task automatic run_reg(input string t, input logic [6:0] opc, input logic [2:0] f3,
                           input logic f7, input logic [3:0] alu, input logic wd,
                           input logic [1:0] sa, input logic sb, input logic [1:0] wbs,
                           input logic pcn, input logic jl, input int waits);
        cur_tag = t; opcode = opc; funct3 = f3; funct7 = f7;
        do_fetch(waits);
        step(18'd0);
        step(ev(L0, L0, L0, L0, L0, wd, alu, L0, L0, sb, sa, 2'd0, L0));
        step(ev(L1, L0, L1, L0, L0, wd, alu, jl, pcn, sb, sa, wbs, L0));
    endtask

    task automatic run_branch(input string t, input logic [2:0] f3, input logic z,
                              input logic n, input logic c, input logic v, input logic tk);
        cur_tag = t; opcode = 7'b1100011; funct3 = f3; funct7 = L0;
        do_fetch(0);
        step(18'd0);
        Zero = z; Negative = n; Carry = c; Overflow = v;
        step(ev(L0, L0, L0, L0, L0, L0, 4'd1, L0, L0, L0, 2'd0, 2'd0, L0));
        // Flip flags: the decision must come from the registered value.
        Zero = ~z; Negative = ~n; Carry = ~c; Overflow = v;
        step(ev(tk, L0, L0, L0, L0, L0, 4'd0, L0, L1, L1, 2'd1, 2'd0, L0));
    endtask

    task automatic run_mem_front(input string t, input logic [6:0] opc);
        cur_tag = t; opcode = opc; funct3 = 3'b011; funct7 = L0;
        do_fetch(0);
        step(18'd0);
        step(ev(L0, L0, L0, L0, L0, L0, 4'd0, L0, L0, L1, 2'd0, 2'd0, L0));
    endtask

    task automatic run_load(input string t, input int waits);
        run_mem_front(t, 7'b0000011);
        dmem_ready = L0;
        for (int i = 0; i < waits; i++)
            step(ev(L0, L0, L0, L1, L0, L0, 4'd0, L0, L0, L1, 2'd0, 2'd0, L0));
        dmem_ready = L1;
        step(ev(L0, L0, L0, L1, L0, L0, 4'd0, L0, L0, L1, 2'd0, 2'd0, L0));
        step(ev(L1, L0, L1, L0, L0, L0, 4'd0, L0, L0, L1, 2'd0, 2'd1, L0));
    endtask

    task automatic run_store(input string t);
        run_mem_front(t, 7'b0100011);
        dmem_ready = L1;
        step(ev(L1, L0, L0, L0, L1, L0, 4'd0, L0, L0, L1, 2'd0, 2'd0, L0));
    endtask

    // Pulse reset between clock edges and check the immediate effect.
    task automatic pulse_reset(input string t);
        cur_tag = t;
        #2;
        rst = L0;
        #1;
        check_eq({t, ":ctrl"}, 64'(obs), 64'd0);
        check_eq({t, ":instret"}, instret, 64'd0);
        model_ret = 64'd0;
        @(posedge clk);
        #1;
        rst = L1;
    endtask

    initial begin
        rst = L0; opcode = 7'd0; funct3 = 3'd0; funct7 = L0;
        Zero = L0; Negative = L0; Carry = L0; Overflow = L0;
        imem_ready = L1; dmem_ready = L1; model_ret = 64'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset:ctrl", 64'(obs), 64'd0);
        check_eq("reset:instret", instret, 64'd0);
        @(posedge clk);
        #1;
        rst = L1;

        //      tag      opcode        f3     f7  alu    wd  sa     sb  wb     pcn jl  waits
        run_reg("add",   7'b0110011, 3'b000, L0, 4'd0, L0, 2'd0, L0, 2'd0, L0, L0, 0);
        run_reg("sub",   7'b0110011, 3'b000, L1, 4'd1, L0, 2'd0, L0, 2'd0, L0, L0, 1);
        run_reg("sltu",  7'b0110011, 3'b011, L0, 4'd9, L0, 2'd0, L0, 2'd0, L0, L0, 0);
        run_reg("and",   7'b0110011, 3'b111, L0, 4'd2, L0, 2'd0, L0, 2'd0, L0, L0, 0);
        run_reg("srai",  7'b0010011, 3'b101, L1, 4'd7, L0, 2'd0, L1, 2'd0, L0, L0, 0);
        run_reg("addi7", 7'b0010011, 3'b000, L1, 4'd0, L0, 2'd0, L1, 2'd0, L0, L0, 0);
        run_reg("subw",  7'b0111011, 3'b000, L1, 4'd1, L1, 2'd0, L0, 2'd0, L0, L0, 0);
        run_reg("srlw",  7'b0111011, 3'b101, L0, 4'd6, L1, 2'd0, L0, 2'd0, L0, L0, 0);
        run_reg("addiw", 7'b0011011, 3'b000, L0, 4'd0, L1, 2'd0, L1, 2'd0, L0, L0, 0);
        run_store("store");
        run_load("load_wait3", 3);
        run_load("load", 0);
        //         tag    f3      Z   N   C   V   taken
        run_branch("beq",  3'b000, L1, L0, L0, L0, L1);
        run_branch("bne",  3'b001, L1, L0, L0, L0, L0);
        run_branch("blt",  3'b100, L0, L1, L0, L0, L1);
        run_branch("bgeu", 3'b111, L0, L0, L1, L0, L1);
        run_branch("bltu", 3'b110, L0, L0, L1, L0, L0);
        run_reg("lui",   7'b0110111, 3'b000, L1, 4'd0, L0, 2'd2, L1, 2'd0, L0, L0, 0);
        run_reg("auipc", 7'b0010111, 3'b000, L0, 4'd0, L0, 2'd1, L1, 2'd0, L0, L0, 0);
        run_reg("jal",   7'b1101111, 3'b101, L1, 4'd0, L0, 2'd1, L1, 2'd2, L1, L0, 0);
        run_reg("jalr",  7'b1100111, 3'b000, L0, 4'd0, L0, 2'd0, L1, 2'd2, L1, L1, 2);

        // Reset while a load is waiting in MEM: nothing may be written.
        run_mem_front("rst_mem", 7'b0000011);
        dmem_ready = L0;
        step(ev(L0, L0, L0, L1, L0, L0, 4'd0, L0, L0, L1, 2'd0, 2'd0, L0));
        pulse_reset("rst_mem_pulse");
        dmem_ready = L1;
        run_store("store_after_rst");

        // Illegal opcode: trap, stay quiet for 20 cycles, then reset.
        cur_tag = "trap"; opcode = 7'b1111111; funct3 = 3'd0; funct7 = L0;
        do_fetch(0);
        step(18'd0);
        dmem_ready = L1;
        for (int i = 0; i < 20; i++) step(ev(L0, L0, L0, L0, L0, L0, 4'd0, L0, L0, L0, 2'd0, 2'd0, L1));
        pulse_reset("trap_rst");
        run_reg("add_after_trap", 7'b0110011, 3'b000, L0, 4'd0, L0, 2'd0, L0, 2'd0, L0, L0, 0);

        @(negedge clk);
        #1;
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
